uart_fifo: RTL and testbench

- Parametrised full-duplex UART, successor to the fixed 8N1 transmitter/receiver pair.
- Generalised in data width, stop bits, baud (derived from parameters) and RX buffering depth; adds framing and overrun error reporting.
- Sits between the CPU I/O decode and the board serial pins. The CPU polls `busy`/`valid` and strobes `wr`/`rd`.

---
 rtl/uart_fifo_if.sv | 29 ++
 rtl/uart_fifo.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_if.sv
// CPU-side bus of uart_fifo: TX strobe/data, RX FIFO pop and head, sticky error flags, plus the serial pins.
// The CPU I/O decode is the master; the UART is the slave.
interface uart_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 tx;
  logic                 wr;
  logic [DATA_BITS-1:0] tx_data;
  logic                 busy;
  logic                 rd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 clr_err;
  logic                 par_odd;
  logic                 par_err;

  modport master (
    output rx, wr, tx_data, rd, clr_err, par_odd,
    input  tx, busy, rx_data, valid, frame_err, overrun, par_err
  );

  modport slave (
    input  rx, wr, tx_data, rd, clr_err, par_odd,
    output tx, busy, rx_data, valid, frame_err, overrun, par_err
  );
endinterface

// File: rtl/uart_fifo.sv
// Parametrised full-duplex UART with an RX FIFO and sticky errors; parity bit added when UART_PARITY_EN is defined.
// Latency: tx/busy change one clk after an accepted wr; valid rises one clk after the stop-bit sample of a good frame.
// Backpressure: wr is ignored while busy except in the last stop clk; a push into a full FIFO (without a pop) is dropped and flags overrun.
module uart_fifo #(
  parameter int CLKFREQ   = 48000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 4
) (
  input logic        clk,
  input logic        reset,
  uart_fifo_if.slave bus
);
  localparam int DIV = CLKFREQ / BAUD;
  localparam int CW  = $clog2(STOP_BITS * DIV) + 1;
  localparam int IW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(RX_DEPTH);

  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(DIV / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

`ifdef UART_PARITY_EN
  localparam state_t AFTER_DATA = S_PAR;
`else
  localparam state_t AFTER_DATA = S_STOP;
`endif

  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_q;
  logic                 busy_q;
  logic                 tx_accept;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  // Accepting in the final stop clock gives back-to-back frames with no idle gap.
  assign tx_accept = bus.wr &&
                     (tx_state == S_IDLE || (tx_state == S_STOP && tx_cnt == STOP_END));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_accept) begin
      tx_state <= S_START;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= bus.tx_data;
      tx_q     <= 1'b0;
      busy_q   <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= (^bus.tx_data) ^ bus.par_odd;
`endif
    end else begin
      case (tx_state)
        S_IDLE: tx_cnt <= '0;
        S_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= S_DATA;
            tx_q     <= tx_shreg[0];
            tx_shreg <= tx_shreg >> 1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_BIT) begin
              tx_state <= AFTER_DATA;
`ifdef UART_PARITY_EN
              tx_q     <= tx_par;
`else
              tx_q     <= 1'b1;
`endif
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_q     <= tx_shreg[0];
              tx_shreg <= tx_shreg >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= S_STOP;
            tx_q     <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == STOP_END) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
            busy_q   <= 1'b0;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;

  state_t               rx_state;
  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_d;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_tick;
  logic                 push;
  logic                 frame_evt;

  assign rx_tick   = (rx_cnt == '0);
  assign push      = (rx_state == S_STOP) && rx_tick && rx_s2;
  assign frame_evt = (rx_state == S_STOP) && rx_tick && !rx_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      if (rx_state != S_IDLE)
        rx_cnt <= rx_tick ? BIT_END : rx_cnt - 1'b1;
      case (rx_state)
        S_IDLE: begin
          // First sample lands mid start bit.
          if (rx_d && !rx_s2) begin
            rx_state <= S_START;
            rx_cnt   <= HALF;
          end
        end
        S_START: begin
          if (rx_tick) begin
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
            rx_idx   <= '0;
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
            rx_idx   <= rx_idx + 1'b1;
            if (rx_idx == LAST_BIT)
              rx_state <= AFTER_DATA;
          end
        end
        S_PAR:   if (rx_tick) rx_state <= S_STOP;
        // Only the first stop bit is sampled so a following start edge is caught early.
        S_STOP:  if (rx_tick) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem [RX_DEPTH];
  logic [AW:0]          wp;
  logic [AW:0]          rp;
  logic                 empty;
  logic                 full;
  logic                 do_pop;
  logic                 do_push;
  logic                 frame_err_q;
  logic                 overrun_q;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = bus.rd && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wp          <= '0;
      rp          <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < RX_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= rx_shreg;
        wp              <= wp + 1'b1;
      end
      if (do_pop)
        rp <= rp + 1'b1;
      // Set wins over a coincident clear.
      if (bus.clr_err) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (frame_evt)
        frame_err_q <= 1'b1;
      if (push && full && !do_pop)
        overrun_q <= 1'b1;
    end
  end

  assign bus.rx_data   = mem[rp[AW-1:0]];
  assign bus.valid     = !empty;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

`ifdef UART_PARITY_EN
  logic par_err_q;
  logic par_evt;

  assign par_evt = (rx_state == S_PAR) && rx_tick && (rx_s2 != ((^rx_shreg) ^ bus.par_odd));

  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else begin
      if (bus.clr_err)
        par_err_q <= 1'b0;
      if (par_evt)
        par_err_q <= 1'b1;
    end
  end

  assign bus.par_err = par_err_q;
`else
  logic unused_par_odd;
  assign unused_par_odd = bus.par_odd;
  assign bus.par_err    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo at DIV=16, 8 data bits, 1 stop bit, 4-entry RX FIFO.
// Expected tx bits and RX bytes are queued when stimulus is driven and drained as the DUT produces them.
`timescale 1ns/1ps
module tb_uart_fifo;
  localparam int DIV   = 16;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FB     = 1 + DB + P + SB;
  localparam int FRAME  = FB * DIV;
  // Cycle (relative to driving the start bit) whose closing edge carries the stop-bit sample.
  localparam int PUSH_C = 2 + DIV / 2 + DIV * (1 + DB + P);

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic loop   = 1'b0;
  logic rx_drv = 1'b1;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  bit         exp_bits[$];
  logic [7:0] exp_bytes[$];

  uart_fifo_if #(.DATA_BITS(DB)) ifc ();

  assign ifc.rx = loop ? ifc.tx : rx_drv;

  uart_fifo #(
    .CLKFREQ  (48000000),
    .BAUD     (3000000),
    .DATA_BITS(DB),
    .STOP_BITS(SB),
    .RX_DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [7:0] d);
    ifc.tx_data = d;
    ifc.wr      = 1'b1;
    step();
    ifc.wr      = 1'b0;
  endtask

  task automatic clear_errors();
    ifc.clr_err = 1'b1;
    step();
    ifc.clr_err = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit stop_lvl, input bit par_flip,
                             input bit pop_at_push);
    logic [15:0] bits;
    logic [7:0]  e;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1+i] = d[i];
    if (P == 1) bits[1+DB] = (^d) ^ ifc.par_odd ^ par_flip;
    bits[1+DB+P] = stop_lvl;
    for (int c = 0; c < (2 + DB + P) * DIV; c++) begin
      rx_drv = bits[c/DIV];
      ifc.rd = pop_at_push && (c == PUSH_C);
      if (ifc.rd) begin
        e = exp_bytes.pop_front();
        n_cmp++;
        if (ifc.rx_data !== e) begin
          n_bad++;
          $display("FAIL pop_at_push_data: rx_data=%h want %h", ifc.rx_data, e);
        end
      end
      step();
    end
    ifc.rd = 1'b0;
    rx_drv = 1'b1;
    repeat (4) step();
  endtask

  task automatic drain_fifo(input string tag);
    int         guard;
    logic [7:0] e;
    while (exp_bytes.size() != 0) begin
      guard = 0;
      while (ifc.valid !== 1'b1 && guard < 4 * FRAME) begin
        step();
        guard++;
      end
      n_cmp++;
      if (ifc.valid !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_valid: valid=%b want 1 (%0d bytes outstanding)", tag, ifc.valid,
                 exp_bytes.size());
        exp_bytes.delete();
      end else begin
        e = exp_bytes.pop_front();
        n_cmp++;
        if (ifc.rx_data !== e) begin
          n_bad++;
          $display("FAIL %s_data: rx_data=%h want %h", tag, ifc.rx_data, e);
        end
        ifc.rd = 1'b1;
        step();
        ifc.rd = 1'b0;
      end
    end
    n_cmp++;
    if (ifc.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_empty: valid=%b want 0", tag, ifc.valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ({ifc.tx, ifc.busy, ifc.valid, ifc.frame_err, ifc.overrun, ifc.par_err} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_outputs: {tx,busy,valid,fe,ovr,pe}=%b want 100000",
               {ifc.tx, ifc.busy, ifc.valid, ifc.frame_err, ifc.overrun, ifc.par_err});
    end
    n_cmp++;
    if (ifc.rx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_rx_data: rx_data=%h want 00", ifc.rx_data);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_tx_frame(input logic [7:0] d, input string tag);
    int n_busy;
    bit cur;
    n_busy = 0;
    cur    = 1'b1;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) exp_bits.push_back(d[i]);
    if (P == 1) exp_bits.push_back((^d) ^ ifc.par_odd);
    for (int i = 0; i < SB; i++) exp_bits.push_back(1'b1);
    drive_wr(d);
    for (int c = 0; c < FRAME + DIV; c++) begin
      if (c % DIV == 0) cur = (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'b1;
      n_cmp++;
      if (ifc.tx !== cur) begin
        n_bad++;
        $display("FAIL %s_tx_c%0d: tx=%b want %b", tag, c, ifc.tx, cur);
      end
      if (ifc.busy === 1'b1) n_busy++;
      step();
    end
    n_cmp++;
    if (n_busy != FRAME) begin
      n_bad++;
      $display("FAIL %s_busy_len: busy high %0d clks want %0d", tag, n_busy, FRAME);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] vals[4];
    int         guard;
    vals = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
    loop = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      exp_bytes.push_back(vals[i]);
      drive_wr(vals[i]);
      n_cmp++;
      if (ifc.tx !== 1'b0 || ifc.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_start_%0d: tx=%b busy=%b want 0 1", i, ifc.tx, ifc.busy);
      end
      if (i == 1) begin
        n_cmp++;
        if (ifc.valid !== 1'b1) begin
          n_bad++;
          $display("FAIL loop_valid_first: valid=%b want 1", ifc.valid);
        end
      end
      if (i < 3) repeat (FRAME - 1) step();
    end
    guard = 0;
    while (ifc.busy !== 1'b0 && guard < FRAME + 10) begin
      step();
      guard++;
    end
    n_cmp++;
    if (ifc.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL loop_busy_timeout: busy=%b want 0", ifc.busy);
    end
    repeat (2 * DIV) step();
    drain_fifo("loop");
    n_cmp++;
    if ({ifc.frame_err, ifc.overrun, ifc.par_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL loop_flags: {fe,ovr,pe}=%b want 000", {ifc.frame_err, ifc.overrun, ifc.par_err});
    end
    loop = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    logic [7:0] f[6];
    f = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_bytes.push_back(f[i]);
      drive_frame(f[i], 1'b1, 1'b0, 1'b0);
    end
    n_cmp++;
    if (ifc.overrun !== 1'b1 || ifc.valid !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set: overrun=%b valid=%b want 1 1", ifc.overrun, ifc.valid);
    end
    clear_errors();
    n_cmp++;
    if (ifc.overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clear: overrun=%b want 0", ifc.overrun);
    end
    exp_bytes.push_back(f[5]);
    drive_frame(f[5], 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (ifc.overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_pop_push: overrun=%b want 0", ifc.overrun);
    end
    drain_fifo("ovr");
  endtask

  task automatic test_frame_err();
    drive_frame(8'h81, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ifc.frame_err !== 1'b1 || ifc.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_err_set: frame_err=%b valid=%b want 1 0", ifc.frame_err, ifc.valid);
    end
    clear_errors();
    n_cmp++;
    if (ifc.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_err_clear: frame_err=%b want 0", ifc.frame_err);
    end
  endtask

  task automatic test_glitch();
    rx_drv = 1'b0;
    repeat (4) step();
    rx_drv = 1'b1;
    repeat (3 * DIV) step();
    n_cmp++;
    if (ifc.valid !== 1'b0 || ifc.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_no_push: valid=%b frame_err=%b want 0 0", ifc.valid, ifc.frame_err);
    end
    exp_bytes.push_back(8'h5A);
    drive_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    drain_fifo("post_glitch");
  endtask

  task automatic test_reset_mid_tx();
    drive_wr(8'h0F);
    repeat (69) step();
    reset = 1'b1;
    step();
    n_cmp++;
    if (ifc.tx !== 1'b1 || ifc.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_tx: tx=%b busy=%b want 1 0", ifc.tx, ifc.busy);
    end
    reset = 1'b0;
    step();
    test_tx_frame(8'hC3, "after_reset");
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    ifc.par_odd = 1'b0;
    test_tx_frame(8'h07, "par_tx");
    exp_bytes.push_back(8'h07);
    drive_frame(8'h07, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (ifc.par_err !== 1'b1 || ifc.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL par_err_set: par_err=%b frame_err=%b want 1 0", ifc.par_err, ifc.frame_err);
    end
    drain_fifo("par_rx");
    clear_errors();
    n_cmp++;
    if (ifc.par_err !== 1'b0) begin
      n_bad++;
      $display("FAIL par_err_clear: par_err=%b want 0", ifc.par_err);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    ifc.wr      = 1'b0;
    ifc.tx_data = '0;
    ifc.rd      = 1'b0;
    ifc.clr_err = 1'b0;
    ifc.par_odd = 1'b0;
    test_reset();
    test_tx_frame(8'h55, "single");
    test_loopback();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid_tx();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
